mem_wb_stage: RTL and testbench

- Final pipeline stage of the CPU. Registers the MEM-stage result and completes loads.
- For loads, waits for the data memory response, then extracts and extends bytes and halfwords.
- Drives the register-file write port (wb_we, wb_write_reg, wb_write_data).
- Raises a stall request while a load is outstanding; flags misaligned, illegal or timed-out loads.

---
 rtl/mem_wb_if.sv | 34 +++
 rtl/mem_wb_stage.sv | 143 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// MEM->WB boundary: MEM-stage operands, data-memory response, flush, and the
// register-file write port driven by the writeback stage.
interface mem_wb_if;
   // Handshake: the stage holds the MEM instruction while stall_req=1; upstream
   // keeps every mem_* input stable until a cycle with stall_req=0 consumes it.
   logic        mem_valid;
   logic        mem_we;
   logic [4:0]  mem_write_reg;
   logic [31:0] mem_alu_result;
   logic        mem_is_load;
   logic [2:0]  mem_load_type;
   logic [1:0]  mem_addr_low;
   logic [31:0] dmem_rdata;
   logic        dmem_rvalid;
   logic        flush;
   logic        stall_req;
   logic        wb_we;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic        load_err;
   logic        dbg_state;

   modport master (
      output mem_valid, mem_we, mem_write_reg, mem_alu_result, mem_is_load,
             mem_load_type, mem_addr_low, dmem_rdata, dmem_rvalid, flush,
      input  stall_req, wb_we, wb_write_reg, wb_write_data, load_err, dbg_state
   );

   modport slave (
      input  mem_valid, mem_we, mem_write_reg, mem_alu_result, mem_is_load,
             mem_load_type, mem_addr_low, dmem_rdata, dmem_rvalid, flush,
      output stall_req, wb_we, wb_write_reg, wb_write_data, load_err, dbg_state
   );
endinterface

// File: rtl/mem_wb_stage.sv
// Writeback stage: registers ALU results, completes loads (waiting on the data
// memory with a timeout), extracts/extends sub-word loads, flags bad loads.
module mem_wb_stage #(
   parameter int LOAD_TIMEOUT = 16
) (
   input logic   clk,
   input logic   rst,
   mem_wb_if.slave bus
);
   localparam int CW = $clog2(LOAD_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

   localparam logic [2:0] LT_LW  = 3'b000;
   localparam logic [2:0] LT_LB  = 3'b001;
   localparam logic [2:0] LT_LBU = 3'b010;
   localparam logic [2:0] LT_LH  = 3'b011;
   localparam logic [2:0] LT_LHU = 3'b100;

   typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic           wb_we_q;
   logic [4:0]     wb_write_reg_q;
   logic [31:0]    wb_write_data_q;
   logic           load_err_q;

   logic           misaligned;
   logic           reserved;
   logic           legal_load;
   logic [7:0]     byte_sel;
   logic [15:0]    half_sel;
   logic [31:0]    load_data;
   logic           write_en;
   logic           stall;

   always_comb begin
      reserved   = (bus.mem_load_type > LT_LHU);
      misaligned = ((bus.mem_load_type == LT_LW) && (bus.mem_addr_low != 2'b00)) ||
                   (((bus.mem_load_type == LT_LH) || (bus.mem_load_type == LT_LHU)) &&
                    bus.mem_addr_low[0]);
      legal_load = bus.mem_is_load && !reserved && !misaligned;
      write_en   = bus.mem_we && (bus.mem_write_reg != 5'd0);
   end

   always_comb begin
      byte_sel  = 8'h00;
      half_sel  = bus.mem_addr_low[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      load_data = bus.dmem_rdata;
      case (bus.mem_addr_low)
         2'd0:    byte_sel = bus.dmem_rdata[7:0];
         2'd1:    byte_sel = bus.dmem_rdata[15:8];
         2'd2:    byte_sel = bus.dmem_rdata[23:16];
         default: byte_sel = bus.dmem_rdata[31:24];
      endcase
      case (bus.mem_load_type)
         LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         LT_LBU:  load_data = {24'h0, byte_sel};
         LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         LT_LHU:  load_data = {16'h0, half_sel};
         default: load_data = bus.dmem_rdata;
      endcase
   end

   // Stall only while a legal load still waits; the timeout cycle itself releases.
   always_comb begin
      stall = 1'b0;
      if (!rst && !bus.flush) begin
         if (state_q == IDLE)
            stall = bus.mem_valid && legal_load && !bus.dmem_rvalid;
         else
            stall = !bus.dmem_rvalid && (cnt_q != CNT_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         wb_we_q         <= 1'b0;
         wb_write_reg_q  <= 5'd0;
         wb_write_data_q <= 32'd0;
         load_err_q      <= 1'b0;
      end else begin
         wb_we_q    <= 1'b0;
         load_err_q <= 1'b0;
         if (bus.flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.mem_valid) begin
                     if (!bus.mem_is_load) begin
                        wb_we_q <= write_en;
                        if (write_en) begin
                           wb_write_reg_q  <= bus.mem_write_reg;
                           wb_write_data_q <= bus.mem_alu_result;
                        end
                     end else if (!legal_load) begin
                        load_err_q <= 1'b1;
                     end else if (bus.dmem_rvalid) begin
                        wb_we_q <= write_en;
                        if (write_en) begin
                           wb_write_reg_q  <= bus.mem_write_reg;
                           wb_write_data_q <= load_data;
                        end
                     end else begin
                        state_q <= WAIT_LOAD;
                        cnt_q   <= '0;
                     end
                  end
               end
               WAIT_LOAD: begin
                  if (bus.dmem_rvalid) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     wb_we_q <= write_en;
                     if (write_en) begin
                        wb_write_reg_q  <= bus.mem_write_reg;
                        wb_write_data_q <= load_data;
                     end
                  end else if (cnt_q == CNT_LAST) begin
                     state_q    <= IDLE;
                     cnt_q      <= '0;
                     load_err_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.stall_req     = stall;
   assign bus.wb_we         = wb_we_q;
   assign bus.wb_write_reg  = wb_write_reg_q;
   assign bus.wb_write_data = wb_write_data_q;
   assign bus.load_err      = load_err_q;
   assign bus.dbg_state     = (state_q == WAIT_LOAD);
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases then randomized instructions, each
// checked against a per-instruction outcome model.
module tb_mem_wb_stage;
  localparam int TO = 16;

  logic clk;
  logic rst;
  mem_wb_if bus ();

  mem_wb_stage #(.LOAD_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [2:0] lt, input logic [1:0] al,
                                             input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * al)) & 32'hFF;
    h = (w >> (al[1] ? 16 : 0)) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  // driver + reference model for one instruction; lat = cycle index of rvalid,
  // fl = cycle index of flush (large = never)
  task automatic do_instr(input logic v, input logic we, input logic [4:0] rd,
                          input logic [31:0] alu, input logic ld, input logic [2:0] lt,
                          input logic [1:0] al, input logic [31:0] rdata,
                          input int lat, input int fl, output int nstall);
    logic legal, legal_v, flushed, exp_we, exp_err;
    int done_c, end_c;
    legal   = ld && (lt <= 3'd4) && !(lt == 3'd0 && al != 2'd0) &&
              !((lt == 3'd3 || lt == 3'd4) && al[0]);
    legal_v = v && legal;
    done_c  = legal_v ? ((lat <= TO) ? lat : TO) : 0;
    flushed = (fl <= done_c);
    end_c   = flushed ? fl : done_c;
    nstall  = 0;
    for (int c = 0; c <= end_c; c++) begin
      bus.mem_valid      = v;
      bus.mem_we         = we;
      bus.mem_write_reg  = rd;
      bus.mem_alu_result = alu;
      bus.mem_is_load    = ld;
      bus.mem_load_type  = lt;
      bus.mem_addr_low   = al;
      bus.dmem_rvalid    = legal_v ? (c == lat) : 1'($urandom_range(0, 1));
      bus.dmem_rdata     = (c == lat) ? rdata : $urandom;
      bus.flush          = (c == fl);
      #1;
      check("stall_req", {31'd0, bus.stall_req},
            {31'd0, legal_v && (c != fl) && (c < lat) && (c < TO)});
      if (bus.stall_req) nstall++;
      @(posedge clk); #1;
      if (c < end_c) begin
        check("wb_we_mid", {31'd0, bus.wb_we}, 32'd0);
        check("load_err_mid", {31'd0, bus.load_err}, 32'd0);
      end
    end
    exp_we = 1'b0;
    exp_err = 1'b0;
    if (!flushed && v) begin
      if (!ld) begin
        exp_we = we && (rd != 0);
        if (exp_we) begin m_reg = rd; m_data = alu; end
      end else if (!legal || lat > TO) begin
        exp_err = 1'b1;
      end else begin
        exp_we = we && (rd != 0);
        if (exp_we) begin m_reg = rd; m_data = load_value(lt, al, rdata); end
      end
    end
    check("wb_we", {31'd0, bus.wb_we}, {31'd0, exp_we});
    check("load_err", {31'd0, bus.load_err}, {31'd0, exp_err});
    check("wb_write_reg", {27'd0, bus.wb_write_reg}, {27'd0, m_reg});
    check("wb_write_data", bus.wb_write_data, m_data);
    check("state_idle", {31'd0, bus.dbg_state}, 32'd0);
    // idle gap: pulses must drop and stray rvalid must be ignored
    bus.mem_valid   = 1'b0;
    bus.flush       = 1'b0;
    bus.dmem_rvalid = 1'($urandom_range(0, 1));
    bus.dmem_rdata  = $urandom;
    #1;
    check("stall_idle", {31'd0, bus.stall_req}, 32'd0);
    @(posedge clk); #1;
    check("wb_we_gap", {31'd0, bus.wb_we}, 32'd0);
    check("load_err_gap", {31'd0, bus.load_err}, 32'd0);
  endtask

  initial begin
    int ns;
    logic v, we, ld;
    logic [4:0] rd;
    logic [2:0] lt;
    logic [1:0] al;
    int lat, fl, r;

    // reset with a legal load presented: stall must stay low
    rst = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_write_reg = 5'd9;
    bus.mem_alu_result = 32'h0; bus.mem_is_load = 1'b1; bus.mem_load_type = 3'd0;
    bus.mem_addr_low = 2'd0; bus.dmem_rdata = 32'h0; bus.dmem_rvalid = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    check("rst_wb_we", {31'd0, bus.wb_we}, 32'd0);
    check("rst_reg", {27'd0, bus.wb_write_reg}, 32'd0);
    check("rst_data", bus.wb_write_data, 32'd0);
    check("rst_err", {31'd0, bus.load_err}, 32'd0);
    check("rst_state", {31'd0, bus.dbg_state}, 32'd0);
    m_reg = 5'd0; m_data = 32'd0;
    bus.mem_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    do_instr(1, 1, 5'd5, 32'h1234_5678, 0, 3'd0, 2'd0, 32'h0, 0, 999, ns);
    check("alu_data", bus.wb_write_data, 32'h1234_5678);
    do_instr(1, 1, 5'd3, 32'h0, 1, 3'd1, 2'd2, 32'h0080_0000, 0, 999, ns);
    check("lb_data", bus.wb_write_data, 32'hFFFF_FF80);
    check("lb_nostall", ns, 0);
    do_instr(1, 1, 5'd3, 32'h0, 1, 3'd2, 2'd2, 32'h0080_0000, 0, 999, ns);
    check("lbu_data", bus.wb_write_data, 32'h0000_0080);
    do_instr(1, 1, 5'd6, 32'h0, 1, 3'd4, 2'd2, 32'hBEEF_0000, 3, 999, ns);
    check("lhu_data", bus.wb_write_data, 32'h0000_BEEF);
    check("lhu_stall_cycles", ns, 3);
    do_instr(1, 1, 5'd7, 32'h0, 1, 3'd3, 2'd1, 32'hFFFF_FFFF, 0, 999, ns);
    check("lh_misaligned_nostall", ns, 0);
    do_instr(1, 1, 5'd8, 32'h0, 1, 3'd0, 2'd0, 32'h0, 999, 999, ns);
    check("timeout_stall_cycles", ns, TO);
    do_instr(1, 1, 5'd8, 32'h0, 1, 3'd0, 2'd0, 32'hCAFE_F00D, TO, 999, ns);
    check("late_rvalid_stall", ns, TO);
    do_instr(1, 1, 5'd9, 32'h0, 1, 3'd0, 2'd0, 32'h1111_2222, 3, 2, ns);
    check("flush_stall_cycles", ns, 2);
    do_instr(1, 1, 5'd0, 32'hDEAD_BEEF, 0, 3'd0, 2'd0, 32'h0, 0, 999, ns);
    do_instr(1, 1, 5'd10, 32'h0, 1, 3'd6, 2'd0, 32'h0, 0, 999, ns);

    // reset in the middle of a wait: no write, no error
    bus.mem_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_write_reg = 5'd11;
    bus.mem_is_load = 1'b1; bus.mem_load_type = 3'd0; bus.mem_addr_low = 2'd0;
    bus.dmem_rvalid = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wait_state", {31'd0, bus.dbg_state}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_stall", {31'd0, bus.stall_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_valid = 1'b0;
    m_reg = 5'd0; m_data = 32'd0;
    check("rst_mid_state", {31'd0, bus.dbg_state}, 32'd0);
    @(posedge clk); #1;
    check("rst_mid_we", {31'd0, bus.wb_we}, 32'd0);
    check("rst_mid_err", {31'd0, bus.load_err}, 32'd0);
    check("rst_mid_data", bus.wb_write_data, 32'd0);

    // randomized instructions
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld = 1'($urandom_range(0, 1));
      lt = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      al = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      lat = (r < 4) ? 0 : (r < 8) ? $urandom_range(1, 5) : $urandom_range(TO - 1, TO + 3);
      fl  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : 999;
      do_instr(v, we, rd, $urandom, ld, lt, al, $urandom, lat, fl, ns);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
